// File: rtl/lcd1602_pkg.sv
// Shared LCD1602 command codes, arbiter state encoding and byte-selection helpers.
// Pure declarations: no latency, no flow control.
package lcd1602_pkg;

  localparam logic [7:0] DISP_SET    = 8'h38;
  localparam logic [7:0] DISP_OFF    = 8'h08;
  localparam logic [7:0] CLR_SCR     = 8'h01;
  localparam logic [7:0] CURSOR_SET1 = 8'h06;
  localparam logic [7:0] CURSOR_SET2 = 8'h0C;
  localparam logic [7:0] ROW1_ADDR   = 8'h80;
  localparam logic [7:0] ROW2_ADDR   = 8'hC0;

  localparam int INIT_LEN = 5;

  typedef enum logic [2:0] {
    S_PWR,
    S_INIT,
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return DISP_SET;
      3'd1:    return DISP_OFF;
      3'd2:    return CLR_SCR;
      3'd3:    return CURSOR_SET1;
      default: return CURSOR_SET2;
    endcase
  endfunction

  // Column 0 lives in the top byte, so byte idx sits at slot 15-idx.
  function automatic logic [7:0] line_byte(input logic [127:0] line, input logic [3:0] idx);
    return line[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd1602_byte_wr.sv
// One LCD1602 bus write: RS/D held for FCLK clocks, EN high for the first FHALF of them.
// Latency FCLK+1 from start to done; start while busy is ignored (no queueing).
module lcd1602_byte_wr #(
  parameter int FCLK  = 100000,
  parameter int FHALF = 50000
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_d
);

  localparam int CW = (FCLK > 1) ? $clog2(FCLK) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      lcd_rs <= 1'b0;
      lcd_d  <= 8'h00;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (cnt == CW'(FCLK - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        lcd_rs <= rs;
        lcd_d  <= data;
      end
    end
  end

  assign lcd_en = busy && (cnt < CW'(FHALF));

endmodule

// File: rtl/lcd1602_write_arbiter.sv
// LCD1602 bus owner: power-up wait + init, then round-robin line writes (address + 16 bytes) for two clients.
// Grant-to-done 17*(FCLK+1)+1 clocks; requests are level-held by clients and only sampled while oReady.
module lcd1602_write_arbiter
  import lcd1602_pkg::*;
#(
  parameter int DELAY_TIME = 1000000,
  parameter int FCLK       = 100000,
  parameter int FHALF      = 50000
) (
  input  logic         CLOCK,
  input  logic         RST_n,
  input  logic [1:0]   iReq,
  input  logic [1:0]   iRow,
  input  logic [127:0] iLine0,
  input  logic [127:0] iLine1,
  output logic [1:0]   oGrant,
  output logic [1:0]   oDone,
  output logic         oReady,
  output logic         LCD1602_RS,
  output logic         LCD1602_RW,
  output logic         LCD1602_EN,
  output logic [7:0]   LCD1602_D
);

  localparam int PW = (DELAY_TIME > 1) ? $clog2(DELAY_TIME) : 1;

  state_t         state, state_nxt;
  logic [PW-1:0]  pwr_cnt, pwr_nxt;
  logic [2:0]     init_idx, init_nxt;
  logic [3:0]     byte_idx, byte_nxt;

  logic           last, cur, row_q, pick, take;
  logic [127:0]   line_q;

  logic           wr_start, wr_rs, wr_busy, wr_done;
  logic [7:0]     wr_data;

  lcd1602_byte_wr #(
    .FCLK  (FCLK),
    .FHALF (FHALF)
  ) u_byte_wr (
    .CLOCK  (CLOCK),
    .RST_n  (RST_n),
    .start  (wr_start),
    .rs     (wr_rs),
    .data   (wr_data),
    .busy   (wr_busy),
    .done   (wr_done),
    .lcd_rs (LCD1602_RS),
    .lcd_en (LCD1602_EN),
    .lcd_d  (LCD1602_D)
  );

  // On a tie the client that was not served last wins.
  assign pick = (iReq == 2'b11) ? ~last : iReq[1];

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= S_PWR;
      pwr_cnt  <= '0;
      init_idx <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_nxt;
      pwr_cnt  <= pwr_nxt;
      init_idx <= init_nxt;
      byte_idx <= byte_nxt;
    end
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      last   <= 1'b1;
      cur    <= 1'b0;
      row_q  <= 1'b0;
      line_q <= '0;
    end else if (take) begin
      last   <= pick;
      cur    <= pick;
      row_q  <= iRow[pick];
      line_q <= pick ? iLine1 : iLine0;
    end
  end

  // Each state starts its first write when the engine is idle and chains the next one on done.
  always_comb begin
    state_nxt = state;
    pwr_nxt   = pwr_cnt;
    init_nxt  = init_idx;
    byte_nxt  = byte_idx;
    wr_start  = 1'b0;
    wr_rs     = 1'b0;
    wr_data   = 8'h00;
    take      = 1'b0;
    case (state)
      S_PWR: begin
        if (pwr_cnt == PW'(DELAY_TIME - 1)) begin
          pwr_nxt   = '0;
          state_nxt = S_INIT;
        end else begin
          pwr_nxt = pwr_cnt + PW'(1);
        end
      end
      S_INIT: begin
        if (wr_done) begin
          if (init_idx == 3'(INIT_LEN - 1)) begin
            init_nxt  = '0;
            state_nxt = S_IDLE;
          end else begin
            init_nxt = init_idx + 3'd1;
            wr_start = 1'b1;
            wr_data  = init_cmd(init_idx + 3'd1);
          end
        end else if (!wr_busy) begin
          wr_start = 1'b1;
          wr_data  = init_cmd(init_idx);
        end
      end
      S_IDLE: begin
        if (|iReq) begin
          take      = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (wr_done) begin
          byte_nxt  = '0;
          state_nxt = S_DATA;
          wr_start  = 1'b1;
          wr_rs     = 1'b1;
          wr_data   = line_byte(line_q, 4'd0);
        end else if (!wr_busy) begin
          wr_start = 1'b1;
          wr_data  = row_q ? ROW2_ADDR : ROW1_ADDR;
        end
      end
      S_DATA: begin
        if (wr_done) begin
          if (byte_idx == 4'd15) begin
            byte_nxt  = '0;
            state_nxt = S_DONE;
          end else begin
            byte_nxt = byte_idx + 4'd1;
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_data  = line_byte(line_q, byte_idx + 4'd1);
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_PWR;
    endcase
  end

  assign oReady     = (state == S_IDLE);
  assign oGrant     = ((state == S_ADDR) || (state == S_DATA)) ? (cur ? 2'b10 : 2'b01) : 2'b00;
  assign oDone      = (state == S_DONE) ? (cur ? 2'b10 : 2'b01) : 2'b00;
  assign LCD1602_RW = 1'b0;

endmodule

// File: tb/tb_lcd1602_write_arbiter.sv
// Bench for lcd1602_write_arbiter: cycle-level protocol model plus directed and random request traffic.
module tb_lcd1602_write_arbiter;

  localparam int DT = 100;
  localparam int FC = 10;
  localparam int FH = 5;

  logic         CLOCK  = 1'b0;
  logic         RST_n  = 1'b1;
  logic [1:0]   iReq   = 2'b00;
  logic [1:0]   iRow   = 2'b00;
  logic [127:0] iLine0 = '0;
  logic [127:0] iLine1 = '0;
  logic [1:0]   oGrant, oDone;
  logic         oReady, LCD1602_RS, LCD1602_RW, LCD1602_EN;
  logic [7:0]   LCD1602_D;

  lcd1602_write_arbiter #(
    .DELAY_TIME (DT),
    .FCLK       (FC),
    .FHALF      (FH)
  ) dut (
    .CLOCK      (CLOCK),
    .RST_n      (RST_n),
    .iReq       (iReq),
    .iRow       (iRow),
    .iLine0     (iLine0),
    .iLine1     (iLine1),
    .oGrant     (oGrant),
    .oDone      (oDone),
    .oReady     (oReady),
    .LCD1602_RS (LCD1602_RS),
    .LCD1602_RW (LCD1602_RW),
    .LCD1602_EN (LCD1602_EN),
    .LCD1602_D  (LCD1602_D)
  );

  always #5 CLOCK = ~CLOCK;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rel_cyc  = 0;
  logic armed    = 1'b0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d after reset release)", name, act, exp, cyc - rel_cyc);
    end
  endtask

  task automatic timeout(input string name, input int lim);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no event within %0d cycles", name, lim);
  endtask

  // ---------------- protocol model ----------------
  logic [7:0] init_seq [5] = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic       m_rs, m_ready, m_last, m_abort;
  logic [7:0] m_d;
  logic [1:0] m_grant, m_done;

  task automatic m_step(input logic en);
    @(negedge CLOCK);
    if (RST_n !== 1'b1) begin
      m_abort = 1'b1;
      return;
    end
    chk("mdl_en", LCD1602_EN, en);
    chk("mdl_rs", LCD1602_RS, m_rs);
    chk("mdl_d", LCD1602_D, m_d);
    chk("mdl_rw", LCD1602_RW, 1'b0);
    chk("mdl_grant", oGrant, m_grant);
    chk("mdl_done", oDone, m_done);
    chk("mdl_ready", oReady, m_ready);
  endtask

  // A byte occupies FC+1 clocks: one start clock showing the old bus, then FH high / FC-FH low.
  task automatic m_byte(input logic rs, input logic [7:0] d);
    m_step(1'b0);
    if (m_abort) return;
    m_rs = rs;
    m_d  = d;
    for (int i = 0; i < FC; i++) begin
      m_step(i < FH);
      if (m_abort) return;
    end
  endtask

  task automatic m_session();
    logic [1:0]   req;
    logic         pk;
    logic         row;
    logic [127:0] line;
    m_abort = 1'b0;
    m_rs = 1'b0; m_d = 8'h00; m_grant = 2'b00; m_done = 2'b00; m_ready = 1'b0; m_last = 1'b1;
    for (int i = 0; i < DT; i++) begin
      m_step(1'b0);
      if (m_abort) return;
    end
    for (int i = 0; i < 5; i++) begin
      m_byte(1'b0, init_seq[i]);
      if (m_abort) return;
    end
    m_step(1'b0);
    if (m_abort) return;
    forever begin
      m_ready = 1'b1; m_grant = 2'b00; m_done = 2'b00;
      m_step(1'b0);
      if (m_abort) return;
      req = iReq;
      if (req != 2'b00) begin
        pk      = (req == 2'b11) ? ~m_last : req[1];
        m_last  = pk;
        line    = pk ? iLine1 : iLine0;
        row     = iRow[pk];
        m_ready = 1'b0;
        m_grant = pk ? 2'b10 : 2'b01;
        m_byte(1'b0, row ? 8'hC0 : 8'h80);
        if (m_abort) return;
        for (int k = 0; k < 16; k++) begin
          m_byte(1'b1, line[127 - 8*k -: 8]);
          if (m_abort) return;
        end
        m_step(1'b0);
        if (m_abort) return;
        m_done  = m_grant;
        m_grant = 2'b00;
        m_step(1'b0);
        if (m_abort) return;
      end
    end
  endtask

  initial begin
    wait (armed);
    forever begin
      wait (RST_n === 1'b1);
      m_session();
      wait (RST_n === 1'b0);
    end
  end

  // ---------------- bus capture: one entry per EN rising edge ----------------
  logic       en_prev = 1'b0;
  logic [8:0] cap [$];

  always @(negedge CLOCK) begin
    if (LCD1602_EN && !en_prev) cap.push_back({LCD1602_RS, LCD1602_D});
    en_prev = LCD1602_EN;
  end

  // ---------------- stimulus helpers ----------------
  task automatic at_pos();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic release_reset();
    @(posedge CLOCK);
    #1;
    RST_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_ready(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLOCK);
      if (oReady === 1'b1) begin
        at = cyc - rel_cyc;
        return;
      end
    end
    timeout("wait_ready", lim);
  endtask

  task automatic wait_grant_rise(input int lim, output logic [1:0] g, output int at);
    g  = 2'b00;
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLOCK);
      if (oGrant == 2'b00) begin
        for (int j = 0; j < lim; j++) begin
          @(negedge CLOCK);
          if (oGrant != 2'b00) begin
            g  = oGrant;
            at = cyc - rel_cyc;
            return;
          end
        end
        break;
      end
    end
    timeout("wait_grant", lim);
  endtask

  task automatic wait_done(input int lim, output logic [1:0] d, output int at);
    d  = 2'b00;
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLOCK);
      if (oDone != 2'b00) begin
        d  = oDone;
        at = cyc - rel_cyc;
        return;
      end
    end
    timeout("wait_done", lim);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int           at, gat, dat;
    logic [1:0]   g, d;
    logic [1:0]   gl [3];
    logic [127:0] t5_line;
    bit           seen;

    #2;
    RST_n = 1'b0;
    armed = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_grant", oGrant, 2'b00);
    chk("rst_done", oDone, 2'b00);
    chk("rst_ready", oReady, 1'b0);
    chk("rst_en", LCD1602_EN, 1'b0);
    chk("rst_rs", LCD1602_RS, 1'b0);
    chk("rst_d", LCD1602_D, 8'h00);
    release_reset();

    // Power-up and init: ready exactly after 100 + 5*11 + 1 clocks.
    wait_ready(400, at);
    chk("t1_ready_cycle", at, 156);

    // Single client 0 line to row 1.
    at_pos();
    iReq   = 2'b01;
    iRow   = 2'b00;
    iLine0 = "HELLO WORLD 1234";
    cap.delete();
    wait_grant_rise(400, g, gat);
    chk("t2_grant", g, 2'b01);
    at_pos();
    iReq = 2'b00;
    wait_done(400, d, dat);
    chk("t2_done", d, 2'b01);
    chk("t2_latency", dat - gat, 17 * (FC + 1) + 1);
    chk("t2_nbytes", cap.size(), 17);
    chk("t2_addr", cap[0], 9'h080);
    chk("t2_first", cap[1], 9'h148);
    chk("t2_last", cap[16], 9'h134);
    @(negedge CLOCK);
    chk("t2_done_pulse", oDone, 2'b00);

    // Line changed and request dropped mid-burst: latched copy goes out.
    at_pos();
    iReq   = 2'b01;
    iRow   = 2'b01;
    iLine0 = "ABCDEFGHIJKLMNOP";
    cap.delete();
    wait_grant_rise(400, g, gat);
    chk("t4_grant", g, 2'b01);
    repeat (60) at_pos();
    iLine0 = {16{8'h20}};
    iReq   = 2'b00;
    wait_done(400, d, dat);
    chk("t4_done", d, 2'b01);
    chk("t4_nbytes", cap.size(), 17);
    chk("t4_addr", cap[0], 9'h0C0);
    chk("t4_mid", cap[8], 9'h148);
    chk("t4_last", cap[16], 9'h150);

    // Reset while data byte 7 has EN high.
    at_pos();
    t5_line = {$urandom, $urandom, $urandom, $urandom};
    iLine0  = t5_line;
    iRow    = 2'b00;
    iReq    = 2'b01;
    cap.delete();
    wait_grant_rise(400, g, gat);
    at_pos();
    iReq = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK);
      if (cap.size() >= 9 && LCD1602_EN) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("t5_byte7", 300);
    chk("t5_byte7", cap[8], {1'b1, t5_line[127 - 56 -: 8]});
    chk("t5_en_before", LCD1602_EN, 1'b1);
    #1;
    RST_n = 1'b0;
    #1;
    chk("t5_en", LCD1602_EN, 1'b0);
    chk("t5_rs", LCD1602_RS, 1'b0);
    chk("t5_d", LCD1602_D, 8'h00);
    chk("t5_grant", oGrant, 2'b00);
    chk("t5_ready", oReady, 1'b0);
    repeat (3) @(posedge CLOCK);
    release_reset();

    // Client 1 requests during init; served on the first idle cycle.
    repeat (120) at_pos();
    iReq   = 2'b10;
    iRow   = 2'b10;
    iLine1 = "client one line!";
    wait_ready(300, at);
    chk("t6_ready_cycle", at, 156);
    @(negedge CLOCK);
    chk("t6_grant", oGrant, 2'b10);

    // Both clients held high: strict alternation starting with client 0.
    at_pos();
    iReq   = 2'b11;
    iLine0 = "0123456789ABCDEF";
    for (int n = 0; n < 3; n++) begin
      wait_grant_rise(500, gl[n], gat);
      if (n == 1) cap.delete();
    end
    chk("t3_grant0", gl[0], 2'b01);
    chk("t3_grant1", gl[1], 2'b10);
    chk("t3_grant2", gl[2], 2'b01);
    chk("t3_c1_nbytes", cap.size(), 17);
    chk("t3_c1_addr", cap[0], 9'h0C0);
    chk("t3_c1_first", cap[1], 9'h163);
    at_pos();
    iReq = 2'b00;
    wait_done(400, d, dat);
    chk("t3_done", d, 2'b01);

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      at_pos();
      if ($urandom_range(0, 15) == 0) iReq = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  iRow = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  iLine0 = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0)  iLine1 = {$urandom, $urandom, $urandom, $urandom};
    end
    iReq = 2'b00;
    wait_ready(400, at);
    repeat (2) @(negedge CLOCK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd1602_write_arbiter.md
Name: lcd1602_write_arbiter

Overview:
- Sole owner of the LCD1602 bus: runs power-up init, then shares the display between two line-update clients.
- Each client presents a 128-bit line (16 ASCII/CGRAM codes) and a target row.
- The arbiter grants round-robin and emits one DDRAM address command plus 16 data bytes through an internal byte-write engine.
- Sits between application content generators (clock, status text) and the LCD1602 pins.

Parameters:
- DELAY_TIME, 1000000: power-up wait in clocks (20 ms at 50 MHz).
- FCLK, 100000: clocks per byte-write cycle (2 ms; covers the clear-screen time).
- FHALF, 50000: clocks EN is held high within FCLK; must be < FCLK.

Ports:
- CLOCK  in  1  system clock.
- RST_n  in  1  reset, asynchronous, active-low.
- iReq  in  2  per-client write request (bit n = client n).
- iRow  in  2  per-client target row: 0 = row1 (0x80), 1 = row2 (0xC0).
- iLine0  in  128  client 0 line; [127:120] is column 0.
- iLine1  in  128  client 1 line.
- oGrant  out  2  one-hot; high for the whole transaction of the granted client.
- oDone  out  2  one-cycle pulse at the end of the granted transaction.
- oReady  out  1  high while the arbiter is in IDLE.
- LCD1602_RS  out  1  0 = command, 1 = data.
- LCD1602_RW  out  1  tied 0.
- LCD1602_EN  out  1  enable strobe.
- LCD1602_D  out  8  data bus.

Behaviour:
Reset values:
- RS = 0, EN = 0, D = 0x00, oGrant = 00, oDone = 00, oReady = 0.
- Round-robin pointer last = 1, so client 0 wins the first tie.
- FSM in S_PWR, all counters 0.
- Reset asserted at any time (including mid-byte) forces these values immediately; the full power-up sequence reruns afterwards.

Byte engine (start, rs, data):
- On start, RS and D are latched and held for the full cycle.
- EN = 1 on counts 0..FHALF-1 and 0 on counts FHALF..FCLK-1.
- done pulses on the cycle after count FCLK-1.
- The FSM issues the next start on the cycle after done, so each byte occupies FCLK+1 clocks.
- start while the engine is busy is ignored.

FSM:
- S_PWR: count DELAY_TIME clocks, then go to S_INIT.
- S_INIT: write commands 0x38, 0x08, 0x01, 0x06, 0x0C with RS = 0, in that order; then go to S_IDLE.
- S_IDLE: oReady = 1. iReq is sampled only in this state.
  - If any request is pending: pick the requesting client other than last (or the single requester).
  - Latch its line and row into an internal 128-bit buffer.
  - Set oGrant, update last, clear oReady, go to S_ADDR.
- S_ADDR: one command write with RS = 0: 0x80 if row = 0, else 0xC0.
- S_DATA: 16 data writes with RS = 1 from the latched buffer, [127:120] first; a 4-bit byte index runs 0..15.
- S_DONE: one cycle. oGrant -> 00, oDone[n] pulses, then back to S_IDLE.
  - oReady rises in the cycle after S_DONE.
  - A request still high there can be granted in that same cycle.

Boundary rules:
- Requests during S_PWR/S_INIT are held pending by the client (level) and served when IDLE is reached. They are not queued internally.
- A client may drop iReq after the grant; the transaction completes regardless.
- iLine/iRow changes after the grant do not affect the bus (latched copy).
- Both clients requesting continuously produce strict alternation: 0, 1, 0, 1.
- Grant-to-oDone latency = 17×(FCLK+1)+1 clocks.

Decomposition:
- Shared package lcd1602_pkg holds:
  - command constants DISP_SET = 0x38, DISP_OFF = 0x08, CLR_SCR = 0x01, CURSOR_SET1 = 0x06, CURSOR_SET2 = 0x0C, ROW1_ADDR = 0x80, ROW2_ADDR = 0xC0;
  - the FSM state encoding.
- Sub-module lcd1602_byte_wr contains the byte engine (counter, EN generation, RS/D hold, done pulse). It is reused by later LCD blocks.

Test Plan:
Bench parameters DELAY_TIME = 100, FCLK = 10, FHALF = 5.
1. Release reset, no requests -> all outputs 0 for 100 clocks. Then 5 EN pulses (5 high/5 low) with RS = 0 and D = 38, 08, 01, 06, 0C. oReady = 1 at clock 100+5×11+1.
2. After ready: iReq = 01, iRow = 0, iLine0 = "HELLO WORLD 1234" -> oGrant = 01. D sequence is 0x80 (RS = 0), then 0x48, 0x45, … 0x34 (RS = 1). oDone = 01 for one cycle, 17×11+1 clocks after the grant.
3. iReq = 11 held high, iRow1 = 1 -> grants in order 01, 10, 01. Client 1 transactions start with 0xC0. No cycle shows both grant bits set.
4. Grant client 0, then change iLine0 to all 0x20 and drop iReq mid-burst -> the original 16 bytes are still emitted and oDone pulses.
5. Assert RST_n low during data byte 7 while EN = 1 -> EN, RS, D, oGrant go to 0 in the same cycle. After release, the 100-clock delay and init sequence repeat.
6. iReq = 10 asserted during S_INIT -> no grant until oReady. Then oGrant = 10 on the first IDLE cycle.
